sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Upstream stage of the SRAM connector. Collects memory requests from N core-side ports and serialises them onto the connector's single port: write, read, byte_en, addr, data_in in; data_out back.
- Round-robin arbitration, registered memory command and per-port routing of read responses.
- Sequences the connector's dump strobe so that a dump only happens after all in-flight traffic has drained.

Parameters:
- N_PORTS, 4: number of requester ports (2..8).
- ADDR_W, 12: memory word address width (64x64 image = 4096 words).
- DATA_W, 8: data word width.
- DUMP_CYCLES, 4: number of cycles mem_dump is held high.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_PORTS  per-port request valid.
- req_ready  out  N_PORTS  per-port accept; at most one bit high.
- req_write  in  N_PORTS  per-port: 1 = write, 0 = read.
- req_byte_en  in  2*N_PORTS  per-port byte enables; port i uses bits [2i+1:2i].
- req_addr  in  N_PORTS*ADDR_W  per-port address, packed by port index.
- req_wdata  in  N_PORTS*DATA_W  per-port write data, packed by port index.
- rsp_valid  out  N_PORTS  one-cycle read-response strobe to the issuing port.
- rsp_rdata  out  DATA_W  read data shared by all ports; qualified by rsp_valid.
- dump_req  in  1  request a memory dump.
- dump_busy  out  1  high while a dump is draining or executing.
- mem_write, mem_read  out  1  memory command strobes.
- mem_byte_en  out  2  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; registered in memory, valid the cycle after mem_read.
- mem_dump  out  1  dump strobe to memory.

Behaviour:
- **Reset:** all outputs 0. Round-robin pointer = 0, state = NORMAL, pipeline empty. Reset wins over every other event.
- **Arbitration (NORMAL only):**
  - Starting at the pointer, the first port with req_valid set is granted.
  - req_ready is a combinational one-hot of that grant. It is all zeros in DRAIN and DUMP.
  - Acceptance = req_valid & req_ready at a posedge. On acceptance, the pointer becomes (granted + 1) mod N_PORTS; otherwise it holds.
  - Requesters must hold valid and payload until accepted.
- **Command stage:**
  - On the acceptance edge E0, mem_addr, mem_wdata and mem_byte_en are registered from the granted port.
  - mem_write = req_write and mem_read = ~req_write, each high for exactly the one cycle after E0.
  - With no acceptance, both strobes are 0 and the other mem_* outputs hold their values.
  - Byte enable 2'b00 is still issued unchanged.
- **Response:**
  - For a read accepted at E0, the port index is registered alongside the command.
  - rsp_valid[port] is high for the one cycle after E1, where E1 = E0 + 1. Read latency is 2 cycles from acceptance.
  - rsp_rdata = mem_rdata, combinational pass-through.
  - Writes produce no response.
  - Back-to-back accepts are sustained, giving 1 request/cycle throughput. Responses return in issue order, each tagged to its own port.
- **State machine:**
  - NORMAL -> DRAIN when dump_req = 1 at an edge. That edge still accepts a request if one is granted.
  - DRAIN: no grants. Stays until both the command register and the response register are empty, which takes at most 2 cycles, then -> DUMP.
  - DUMP: mem_dump = 1 for exactly DUMP_CYCLES cycles (internal counter), then -> NORMAL with mem_dump = 0.
  - dump_busy = 1 in DRAIN and DUMP.
  - dump_req while dump_busy is ignored; it is not queued.
- **Reset mid-dump:** at the reset edge, mem_dump, dump_busy and any pending rsp_valid go to 0. The counter clears.
- **Width rules:**
  - The pointer is ceil(log2 N_PORTS) bits and wraps from N_PORTS-1 to 0.
  - The DUMP counter is wide enough for DUMP_CYCLES and saturates at done.

Test Plan:
- **Write then read:** port 2 writes 0xA5 to addr 0x005 (byte_en 2'b01), then port 2 reads 0x005 -> mem_write one cycle with mem_addr 0x005 and mem_wdata 0xA5; rsp_valid = 4'b0100 exactly 2 cycles after the read is accepted, with rsp_rdata 0xA5.
- **Round-robin fairness:** all 4 ports hold valid reads of addrs 0x010..0x013 from reset -> accept order is ports 0,1,2,3 on consecutive cycles; rsp_valid bits are 0001, 0010, 0100, 1000 on consecutive cycles, carrying the data for 0x010..0x013.
- **Pointer wrap:** after port 3 is accepted, ports 0 and 3 both valid -> port 0 is granted first, then port 3.
- **Dump during streaming reads:** pulse dump_req while reads are streaming -> req_ready = 0 from the next cycle; in-flight responses still arrive; mem_dump is high for 4 cycles only after the pipeline is empty; dump_busy is high throughout; grants resume after dump_busy falls.
- **Reset mid-dump:** assert rst during cycle 2 of DUMP -> mem_dump, dump_busy, rsp_valid and req_ready are 0 on the next cycle; after rst deasserts, port 0 is granted first.
- **Dump while busy:** dump_req again while dump_busy is high -> no second dump; mem_dump is high for exactly 4 cycles total.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter that serialises N requester ports onto one SRAM port.
// Latency: command registered 1 cycle after accept, read response 2 cycles after accept.
// Backpressure: req_ready is a one-hot grant, forced low during reset, drain and dump.
module sram_req_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int DUMP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS-1:0]        req_write,
  input  logic [2*N_PORTS-1:0]      req_byte_en,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  input  logic                      dump_req,
  output logic                      dump_busy,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [1:0]                mem_byte_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_dump
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(DUMP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_DRAIN  = 2'd1,
    S_DUMP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [PTR_W:0]     scan_idx;
  logic [N_PORTS-1:0] grant_oh;
  logic               accept;
  logic [PTR_W-1:0]   cmd_port;
  logic [CNT_W-1:0]   dump_cnt;

  // Search for the first valid port at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      scan_idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (scan_idx >= (PTR_W + 1)'(N_PORTS)) begin
        scan_idx = scan_idx - (PTR_W + 1)'(N_PORTS);
      end
      if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign grant_oh  = grant_found ? (N_PORTS'(1) << grant_idx) : '0;
  assign req_ready = (state == S_NORMAL && !rst) ? grant_oh : '0;
  assign accept    = |(req_valid & req_ready);

  // Pointer moves past the port just served; otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Command register: strobes last one cycle, address/data/enables hold between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_byte_en <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cmd_port    <= '0;
    end else begin
      mem_write <= accept &  req_write[grant_idx];
      mem_read  <= accept & ~req_write[grant_idx];
      if (accept) begin
        mem_byte_en <= req_byte_en[2*int'(grant_idx) +: 2];
        mem_addr    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        mem_wdata   <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        cmd_port    <= grant_idx;
      end
    end
  end

  // Response register: the memory returns read data the cycle after mem_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
    end else begin
      rsp_valid <= mem_read ? (N_PORTS'(1) << cmd_port) : '0;
    end
  end

  assign rsp_rdata = mem_rdata;

  // Dump sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. Grants stop on entering DRAIN, so once the command register is
  // empty the response register empties on the same edge and the dump may start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL: if (dump_req)                  state_nxt = S_DRAIN;
      S_DRAIN:  if (!(mem_write || mem_read))  state_nxt = S_DUMP;
      S_DUMP:   if (dump_cnt == CNT_LAST)      state_nxt = S_NORMAL;
      default:                                 state_nxt = S_NORMAL;
    endcase
  end

  // Counts dump cycles; cleared outside DUMP and saturates at the final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_cnt <= '0;
    end else if (state != S_DUMP) begin
      dump_cnt <= '0;
    end else if (dump_cnt != CNT_LAST) begin
      dump_cnt <= dump_cnt + CNT_W'(1);
    end
  end

  assign mem_dump  = (state == S_DUMP);
  assign dump_busy = (state != S_NORMAL);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a command/response scoreboard.
// Commands are expected 1 cycle and read responses 2 cycles after acceptance.
// Requesters hold valid until the bench observes acceptance.
module tb_sram_req_arbiter;

  localparam int NP = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   req_write;
  logic [2*NP-1:0] req_byte_en;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            dump_req;
  logic            dump_busy;
  logic            mem_write;
  logic            mem_read;
  logic [1:0]      mem_byte_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_dump;

  sram_req_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DUMP_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte_en(req_byte_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dump_req(dump_req), .dump_busy(dump_busy),
    .mem_write(mem_write), .mem_read(mem_read), .mem_byte_en(mem_byte_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_dump(mem_dump)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        due;
    logic      wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    be;
  } cmd_t;

  typedef struct {
    int            due;
    logic [NP-1:0] oh;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic [NP-1:0] acc_last = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: registered read, byte lane 0 enables the write.
  always @(posedge clk) begin
    if (mem_write && mem_byte_en[0]) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard: compare due entries, then predict from this cycle's handshake.
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    logic [NP-1:0] acc;
    cyc++;
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      c = cmd_q.pop_front();
      chk("cmd_write", mem_write, c.wr);
      chk("cmd_read", mem_read, !c.wr);
      chk("cmd_addr", mem_addr, c.addr);
      chk("cmd_be", mem_byte_en, c.be);
      if (c.wr) chk("cmd_wdata", mem_wdata, c.data);
    end else begin
      chk("cmd_idle", {mem_write, mem_read}, 2'b00);
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      chk("rsp_valid", rsp_valid, r.oh);
      chk("rsp_rdata", rsp_rdata, r.data);
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    acc = req_valid & req_ready;
    acc_last = acc;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        c.due  = cyc + 1;
        c.wr   = req_write[p];
        c.addr = req_addr[p*AW +: AW];
        c.data = req_wdata[p*DW +: DW];
        c.be   = req_byte_en[2*p +: 2];
        cmd_q.push_back(c);
        if (c.wr) begin
          if (c.be[0]) shadow[c.addr] = c.data;
        end else begin
          r.due  = cyc + 2;
          r.oh   = NP'(1) << p;
          r.data = shadow[c.addr];
          rsp_q.push_back(r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_last;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] be);
    req_write[p]         = wr;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
    req_byte_en[2*p +: 2] = be;
    req_valid[p]         = 1'b1;
  endtask

  initial begin
    int  ndump;
    logic found;
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]    = DW'(i) ^ 8'h3C;
      shadow[i] = DW'(i) ^ 8'h3C;
    end
    rst = 1'b1; dump_req = 1'b0;
    req_valid = '0; req_write = '0; req_byte_en = '0; req_addr = '0; req_wdata = '0;
    repeat (2) step();

    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_strobes", {mem_write, mem_read, mem_dump, dump_busy}, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_addr", mem_addr, 0);
    step(); rst = 1'b0;

    // Write then read on port 2
    set_req(2, 1'b1, 12'h005, 8'hA5, 2'b01);
    @(negedge clk); chk("t1_wr_grant", req_ready, 4'b0100);
    step();
    set_req(2, 1'b0, 12'h005, 8'h00, 2'b11);
    @(negedge clk);
    chk("t1_wr_grant2", req_ready, 4'b0100);
    chk("t1_wr_strobe", mem_write, 1);
    chk("t1_wr_addr", mem_addr, 12'h005);
    chk("t1_wr_data", mem_wdata, 8'hA5);
    step();
    @(negedge clk); chk("t1_rd_strobe", mem_read, 1);
    step();
    @(negedge clk);
    chk("t1_rsp", rsp_valid, 4'b0100);
    chk("t1_rdata", rsp_rdata, 8'hA5);
    step();

    // Round robin from reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < NP; k++) set_req(k, 1'b0, AW'(12'h010 + k), 8'h00, 2'b11);
    for (int k = 0; k < NP; k++) begin
      @(negedge clk); chk($sformatf("t2_grant%0d", k), req_ready, NP'(1) << k);
      step();
    end

    // Pointer wrap
    set_req(0, 1'b0, 12'h020, 8'h00, 2'b11);
    set_req(3, 1'b0, 12'h023, 8'h00, 2'b11);
    @(negedge clk); chk("t3_first", req_ready, 4'b0001);
    step();
    @(negedge clk); chk("t3_second", req_ready, 4'b1000);
    step();

    // Dump during streaming reads
    for (int k = 0; k < NP; k++) set_req(k, 1'b0, AW'(12'h030 + k), 8'h00, 2'b11);
    @(negedge clk); chk("t4_g0", req_ready, 4'b0001);
    step();
    dump_req = 1'b1;
    @(negedge clk); chk("t4_g1", req_ready, 4'b0010);
    step();
    dump_req = 1'b0;
    @(negedge clk);
    chk("t4_ready_off", req_ready, 0);
    chk("t4_busy", dump_busy, 1);
    ndump = 0;
    for (int i = 0; i < 30; i++) begin
      if (!dump_busy) break;
      chk("t4_noready", req_ready, 0);
      if (mem_dump) begin
        ndump++;
        chk("t4_quiet", {mem_read, mem_write, |rsp_valid}, 0);
      end
      step();
      @(negedge clk);
    end
    chk("t4_done", dump_busy, 0);
    chk("t4_ndump", ndump, 4);
    chk("t4_resume", req_ready, 4'b0100);
    step();
    @(negedge clk); chk("t4_g3", req_ready, 4'b1000);
    step();

    // Reset mid-dump; pointer first moved to 2
    set_req(1, 1'b0, 12'h040, 8'h00, 2'b11);
    @(negedge clk); chk("t5_g1", req_ready, 4'b0010);
    step();
    repeat (3) step();
    dump_req = 1'b1; step(); dump_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_dump) begin found = 1'b1; break; end
      step();
    end
    chk("t5_dump_seen", found, 1);
    step();
    rst = 1'b1;
    set_req(0, 1'b0, 12'h050, 8'h00, 2'b11);
    set_req(2, 1'b0, 12'h052, 8'h00, 2'b11);
    @(negedge clk); chk("t5_dump_cyc2", mem_dump, 1);
    step();
    @(negedge clk);
    chk("t5_rst_dump", mem_dump, 0);
    chk("t5_rst_busy", dump_busy, 0);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    step(); rst = 1'b0;
    @(negedge clk); chk("t5_first", req_ready, 4'b0001);
    step();
    @(negedge clk); chk("t5_second", req_ready, 4'b0100);
    step();
    repeat (3) step();

    // Dump request while busy is ignored
    dump_req = 1'b1;
    ndump = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_dump) ndump++;
      if (i == 2) chk("t6_busy_at_req", dump_busy, 1);
      step();
      dump_req = (i == 1);
    end
    chk("t6_ndump", ndump, 4);
    chk("t6_idle", dump_busy, 0);

    repeat (4) step();
    chk("sb_cmd_empty", cmd_q.size(), 0);
    chk("sb_rsp_empty", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
